tile_plotter: RTL

Pixel-drawing stage directly downstream of the game controller. Consumes the controller's one-cycle `plot` strobe and `s_color` select, plus the player cell position. Rasterises one TILE_W x TILE_H tile into per-pixel writes for the 160x120 VGA adapter. Holds one request in a one-deep pending slot, so the controller's back-to-back ERASE/DRAW strobes are both serviced with no handshake back to it.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/tile_plotter_if.sv | 34 +++
 rtl/tile_pixel_counter.sv | 43 ++++
 rtl/tile_plotter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions for the 160x120 adapter path.
// Provides pixel/colour widths, named colours, screen limits, the plotter
// FSM state type and the tile request record used by tile_plotter.
package vga_pkg;

  localparam int VGA_X_W  = 8;
  localparam int VGA_Y_W  = 7;
  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic {
    IDLE    = 1'b0,
    DRAWING = 1'b1
  } plot_state_e;

  // One tile request: pixel origin of the tile plus its fill colour.
  typedef struct packed {
    logic [VGA_X_W-1:0]  x;
    logic [VGA_Y_W-1:0]  y;
    logic [COLOUR_W-1:0] colour;
  } tile_req_t;

endpackage

// File: rtl/tile_plotter_if.sv
// Request/pixel bus between the game controller, tile_plotter and the VGA
// adapter.
//   plot, s_color, cell_x, cell_y : tile request from the controller
//   vga_x, vga_y, vga_colour, vga_plot : per-pixel write to the adapter
//   busy, done, overrun : plotter status
// modport slave is the plotter's view; modport master is the requester's.
interface tile_plotter_if #(
  parameter int CX_W = 6,
  parameter int CY_W = 5
);

  logic                          plot;
  logic                          s_color;
  logic [CX_W-1:0]               cell_x;
  logic [CY_W-1:0]               cell_y;
  logic [vga_pkg::VGA_X_W-1:0]   vga_x;
  logic [vga_pkg::VGA_Y_W-1:0]   vga_y;
  logic [vga_pkg::COLOUR_W-1:0]  vga_colour;
  logic                          vga_plot;
  logic                          busy;
  logic                          done;
  logic                          overrun;

  modport slave (
    input  plot, s_color, cell_x, cell_y,
    output vga_x, vga_y, vga_colour, vga_plot, busy, done, overrun
  );

  modport master (
    output plot, s_color, cell_x, cell_y,
    input  vga_x, vga_y, vga_colour, vga_plot, busy, done, overrun
  );

endinterface

// File: rtl/tile_pixel_counter.sv
// Column/row scan counter for one tile, row-major with col fastest.
//   clk, reset : clock and synchronous active-high reset
//   clear      : force col=row=0 (priority over enable)
//   enable     : advance one pixel
//   col, row   : current pixel offset inside the tile
//   last       : current pixel is (TILE_W-1, TILE_H-1)
module tile_pixel_counter #(
  parameter int TILE_W = 4,
  parameter int TILE_H = 4,
  localparam int CW = (TILE_W > 1) ? $clog2(TILE_W) : 1,
  localparam int RW = (TILE_H > 1) ? $clog2(TILE_H) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(TILE_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(TILE_H - 1);

  assign last = (col == COL_MAX) && (row == ROW_MAX);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (enable) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_plotter.sv
// Tile rasteriser between the game controller and the 160x120 VGA adapter.
// Each plot strobe becomes TILE_W x TILE_H consecutive pixel writes. A
// one-deep pending slot absorbs a second strobe that arrives mid-tile, so an
// ERASE/DRAW pair issued back to back is drawn with no handshake.
//   clk, reset : clock and synchronous active-high reset
//   bus        : tile_plotter_if.slave (request in, pixel writes and status out)
module tile_plotter
  import vga_pkg::*;
#(
  parameter int                  TILE_W    = 4,
  parameter int                  TILE_H    = 4,
  parameter int                  CX_W      = 6,
  parameter int                  CY_W      = 5,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = BLACK,
  parameter logic [COLOUR_W-1:0] FG_COLOUR = WHITE
) (
  input logic           clk,
  input logic           reset,
  tile_plotter_if.slave bus
);

  localparam int CW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int RW = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  plot_state_e state, state_next;
  tile_req_t   active, active_next;
  tile_req_t   pend, pend_next;
  tile_req_t   req_in;
  logic        pend_valid, pend_valid_next;
  logic        done_q, done_next;
  logic        overrun_q, overrun_next;
  logic        cnt_clear, cnt_enable, last_pixel;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [CX_W-1:0] cell_x;
  logic [CY_W-1:0] cell_y;

  assign cell_x = bus.cell_x;
  assign cell_y = bus.cell_y;

  // Tile origin in pixels; oversized products wrap into the adapter's range.
  always_comb begin
    req_in.x      = VGA_X_W'(cell_x) * VGA_X_W'(TILE_W);
    req_in.y      = VGA_Y_W'(cell_y) * VGA_Y_W'(TILE_H);
    req_in.colour = bus.s_color ? FG_COLOUR : BG_COLOUR;
  end

  tile_pixel_counter #(
    .TILE_W (TILE_W),
    .TILE_H (TILE_H)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .col    (col),
    .row    (row),
    .last   (last_pixel)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next      = state;
    active_next     = active;
    pend_next       = pend;
    pend_valid_next = pend_valid;
    done_next       = 1'b0;
    overrun_next    = overrun_q;
    cnt_clear       = 1'b0;
    cnt_enable      = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.plot) begin
          active_next = req_in;
          cnt_clear   = 1'b1;
          state_next  = DRAWING;
        end
      end

      DRAWING: begin
        if (last_pixel) begin
          done_next = 1'b1;
          if (pend_valid) begin
            // Pending tile goes live; a coincident strobe refills the slot.
            active_next     = pend;
            cnt_clear       = 1'b1;
            pend_valid_next = bus.plot;
            if (bus.plot) pend_next = req_in;
          end else if (bus.plot) begin
            active_next = req_in;
            cnt_clear   = 1'b1;
          end else begin
            // Counters hold on the last pixel so vga_x/vga_y keep their values.
            state_next = IDLE;
          end
        end else begin
          cnt_enable = 1'b1;
          if (bus.plot) begin
            if (!pend_valid) begin
              pend_next       = req_in;
              pend_valid_next = 1'b1;
            end else begin
              overrun_next = 1'b1;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      active     <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state      <= state_next;
      active     <= active_next;
      pend       <= pend_next;
      pend_valid <= pend_valid_next;
      done_q     <= done_next;
      overrun_q  <= overrun_next;
    end
  end

  assign bus.vga_x      = active.x + VGA_X_W'(col);
  assign bus.vga_y      = active.y + VGA_Y_W'(row);
  assign bus.vga_colour = active.colour;
  assign bus.vga_plot   = (state == DRAWING);
  assign bus.busy       = (state == DRAWING);
  assign bus.done       = done_q;
  assign bus.overrun    = overrun_q;

endmodule
